// File: rtl/prbs5_checker.sv
// -----------------------------------------------------------------------------
// prbs5_checker
//
// Receive-side checker for the serial x^5+x^2+1 pattern (generator seed
// 5'b11111, serial output taken from stage 4). The last five received bits
// predict the next one, s(n+5) = s(n+2) ^ s(n), so the checker synchronises
// itself to the incoming stream without any seed exchange. A HUNT/LOCK state
// machine qualifies the link, and mispredicted bits in LOCK are flagged and
// counted.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_b    in   1      asynchronous active-low reset
//   din      in   1      received serial bit
//   din_vld  in   1      din is sampled only when this is 1 (0 holds all state)
//   clr_err  in   1      synchronous clear of err_cnt (wins over an increment,
//                        leaving 1 if an error lands in the same cycle)
//   locked   out  1      1 while in LOCK
//   err      out  1      one-cycle pulse per mispredicted bit while in LOCK
//   err_cnt  out  ERR_W  saturating count of LOCK errors
//   bit_cnt  out  32     (only with PRBS5_CHK_BITCNT_EN) saturating count of
//                        bits compared while in LOCK, cleared by clr_err
//
// Optional feature macro: PRBS5_CHK_BITCNT_EN adds the bit_cnt output.
//
// All outputs are registered; err/locked follow the din_vld sample by 1 clk.
// -----------------------------------------------------------------------------
module prbs5_checker #(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_THR = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             din,
   input  logic             din_vld,
   input  logic             clr_err,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
`ifdef PRBS5_CHK_BITCNT_EN
   ,
   output logic [31:0]      bit_cnt
`endif
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(LOSS_THR + 1);

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t             state_q,   state_d;
   logic [4:0]         hist_q,    hist_d;
   logic [2:0]         fill_q,    fill_d;
   logic [GOOD_W-1:0]  good_q,    good_d;
   logic [BAD_W-1:0]   bad_q,     bad_d;
   logic               locked_q,  locked_d;
   logic               err_q,     err_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

   logic exp_bit;
   logic mism;
   logic cmp;
   logic err_evt;

   // hist[0] is the newest bit, so hist[4] = s(n) and hist[2] = s(n+2).
   assign exp_bit = hist_q[2] ^ hist_q[4];

   // An all-zero history followed by another zero would self-predict forever;
   // a legal stream never holds five zeros, so that case is a mismatch.
   assign mism    = (din ^ exp_bit) | ((hist_q == 5'd0) & ~din);

   // Compare only once five valid bits have filled the history.
   assign cmp     = din_vld && (fill_q == 3'd5);
   assign err_evt = cmp && (state_q == ST_LOCK) && mism;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_HUNT;
         hist_q    <= '0;
         fill_q    <= '0;
         good_q    <= '0;
         bad_q     <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      good_d    = good_q;
      bad_d     = bad_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      // History shifts in both states, so a return to HUNT resyncs at once.
      if (din_vld) begin
         hist_d = {hist_q[3:0], din};
         if (fill_q != 3'd5) begin
            fill_d = fill_q + 3'd1;
         end
      end

      if (cmp) begin
         case (state_q)
            ST_HUNT: begin
               if (mism) begin
                  good_d = '0;
               end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                  state_d = ST_LOCK;
                  good_d  = '0;
                  bad_d   = '0;
               end else begin
                  good_d = good_q + 1'b1;
               end
            end
            ST_LOCK: begin
               if (mism) begin
                  err_d = 1'b1;
                  if (bad_q == BAD_W'(LOSS_THR - 1)) begin
                     state_d = ST_HUNT;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + 1'b1;
                  end
               end else begin
                  bad_d = '0;
               end
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end

      // Clear wins, but an error in the clearing cycle is still counted.
      if (clr_err) begin
         err_cnt_d = err_evt ? ERR_W'(1) : '0;
      end else if (err_evt && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end

      locked_d = (state_d == ST_LOCK);
   end

   assign locked  = locked_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

`ifdef PRBS5_CHK_BITCNT_EN
   logic [31:0] bit_cnt_q, bit_cnt_d;
   logic        cnt_evt;

   // Every bit compared in LOCK contributes to the error-rate denominator.
   assign cnt_evt = cmp && (state_q == ST_LOCK);

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (clr_err) begin
         bit_cnt_d = cnt_evt ? 32'd1 : 32'd0;
      end else if (cnt_evt && (bit_cnt_q != 32'hFFFF_FFFF)) begin
         bit_cnt_d = bit_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         bit_cnt_q <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs5_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs5_checker
//
// Directed bench for prbs5_checker. The legal stream is one 31-bit period of
// the x^5+x^2+1 generator (seed 11111, stage-4 output), written out as a table.
// Inputs change on the falling edge, outputs are sampled on the next falling
// edge after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_prbs5_checker;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       din;
   logic       din_vld;
   logic       clr_err;
   logic       locked;
   logic       err;
   logic [7:0] err_cnt;
`ifdef PRBS5_CHK_BITCNT_EN
   logic [31:0] bit_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // One generator period s0..s30.
   string pat = "1110001101110101000010010110011";
   bit    seq [31];
   int    pos;

   always #5 clk = ~clk;

   prbs5_checker #(
      .LOCK_CNT (8),
      .LOSS_THR (4),
      .ERR_W    (8)
   ) dut (
      .clk     (clk),
      .rst_b   (rst_b),
      .din     (din),
      .din_vld (din_vld),
      .clr_err (clr_err),
      .locked  (locked),
      .err     (err),
      .err_cnt (err_cnt)
`ifdef PRBS5_CHK_BITCNT_EN
      ,
      .bit_cnt (bit_cnt)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic d, input logic v, input logic c);
      din     = d;
      din_vld = v;
      clr_err = c;
      @(posedge clk);
      @(negedge clk);
      din_vld = 1'b0;
      clr_err = 1'b0;
   endtask

   // Next legal stream bit, optionally inverted.
   task automatic send(input logic flip, input logic clr);
      drive(seq[pos] ^ flip, 1'b1, clr);
      pos = (pos + 1) % 31;
   endtask

   task automatic do_reset();
      din     = 1'b0;
      din_vld = 1'b0;
      clr_err = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      pos   = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int flips;
      int guard;
      int vc;

      for (int i = 0; i < 31; i++) begin
         seq[i] = (pat.getc(i) == "1");
      end
      rst_b   = 1'b0;
      din     = 1'b0;
      din_vld = 1'b0;
      clr_err = 1'b0;

      // Scenario 1: reset values, then lock after 5 fill + 8 matches.
      do_reset();
      check_val("rst_locked", locked, 0);
      check_val("rst_err", err, 0);
      check_val("rst_err_cnt", err_cnt, 0);
`ifdef PRBS5_CHK_BITCNT_EN
      check_val("rst_bit_cnt", bit_cnt, 0);
`endif
      for (int i = 0; i < 31; i++) begin
         send(1'b0, 1'b0);
         check_val($sformatf("s1_err_b%0d", i), err, 0);
         if (i == 11) check_val("s1_locked_b11", locked, 0);
         if (i == 12) check_val("s1_locked_b12", locked, 1);
      end
      check_val("s1_err_cnt", err_cnt, 0);
      check_val("s1_locked_end", locked, 1);
`ifdef PRBS5_CHK_BITCNT_EN
      check_val("s1_bit_cnt", bit_cnt, 18);
`endif
      $display("scenario 1: lock from reset complete");

      // Scenario 3: stream ended on s26..s30 = 1,0,0,1,1, so zeros mispredict
      // four times in a row, then the zero guard keeps the checker in HUNT.
      for (int z = 1; z <= 6; z++) begin
         drive(1'b0, 1'b1, 1'b0);
         check_val($sformatf("s3_err_z%0d", z), err, (z <= 4) ? 1 : 0);
         check_val($sformatf("s3_locked_z%0d", z), locked, (z <= 3) ? 1 : 0);
      end
      check_val("s3_err_cnt", err_cnt, 4);
`ifdef PRBS5_CHK_BITCNT_EN
      check_val("s3_bit_cnt", bit_cnt, 22);
`endif
      for (int z = 0; z < 10; z++) drive(1'b0, 1'b1, 1'b0);
      check_val("s3_locked_hold", locked, 0);
      check_val("s3_err_cnt_hold", err_cnt, 4);
      $display("scenario 3: zero stream loses lock complete");

      // Scenario 2: single inverted bit (s22) -> errors at offsets 0, 3, 5.
      do_reset();
      for (int i = 0; i < 22; i++) send(1'b0, 1'b0);
      check_val("s2_locked_pre", locked, 1);
      for (int j = 0; j <= 10; j++) begin
         send((j == 0), 1'b0);
         check_val($sformatf("s2_err_o%0d", j), err, (j == 0 || j == 3 || j == 5) ? 1 : 0);
      end
      check_val("s2_err_cnt", err_cnt, 3);
      check_val("s2_locked_post", locked, 1);
      $display("scenario 2: single bit flip complete");

      // Scenario 6: asynchronous reset mid-LOCK, then relock.
      @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      check_val("s6_locked_async", locked, 0);
      check_val("s6_err_cnt_async", err_cnt, 0);
`ifdef PRBS5_CHK_BITCNT_EN
      check_val("s6_bit_cnt_async", bit_cnt, 0);
`endif
      @(negedge clk);
      rst_b = 1'b1;
      pos   = 0;
      for (int i = 0; i < 13; i++) begin
         send(1'b0, 1'b0);
         if (i == 11) check_val("s6_locked_b11", locked, 0);
         if (i == 12) check_val("s6_locked_b12", locked, 1);
      end
      check_val("s6_err_cnt_relock", err_cnt, 0);
      $display("scenario 6: async reset and relock complete");

      // Scenario 4: din_vld pattern 1,0,0 with garbage din on idle cycles.
      do_reset();
      vc = 0;
      for (int k = 0; k < 42; k++) begin
         if (k % 3 == 0) begin
            send(1'b0, 1'b0);
            vc++;
         end else begin
            drive(~seq[pos], 1'b0, 1'b0);
         end
         check_val($sformatf("s4_locked_c%0d", k), locked, (vc >= 13) ? 1 : 0);
         check_val($sformatf("s4_err_c%0d", k), err, 0);
      end
      check_val("s4_err_cnt", err_cnt, 0);
      $display("scenario 4: gapped valid complete");

      // Scenario 5: 85 isolated 0->1 flips give 255 errors; then saturation
      // and the clr_err priority rule.
      do_reset();
      for (int i = 0; i < 13; i++) send(1'b0, 1'b0);
      check_val("s5_locked_pre", locked, 1);
      flips = 0;
      guard = 0;
      while (flips < 85 && guard < 2000) begin
         if (seq[pos] == 1'b0) begin
            send(1'b1, 1'b0);
            for (int j = 0; j < 7; j++) send(1'b0, 1'b0);
            flips++;
         end else begin
            send(1'b0, 1'b0);
         end
         guard++;
      end
      check_val("s5_flip_budget", flips, 85);
      check_val("s5_err_cnt_255", err_cnt, 255);
      check_val("s5_locked_mid", locked, 1);
      while (seq[pos] != 1'b0) send(1'b0, 1'b0);
      send(1'b1, 1'b0);                       // offset 0: error at saturation
      check_val("s5_sat_err", err, 1);
      check_val("s5_sat_cnt", err_cnt, 255);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      send(1'b0, 1'b1);                       // offset 3: error with clear
      check_val("s5_clr_err_pulse", err, 1);
      check_val("s5_clr_with_err", err_cnt, 1);
      send(1'b0, 1'b0);
      check_val("s5_o4_err", err, 0);
      send(1'b0, 1'b0);                       // offset 5: error, no clear
      check_val("s5_o5_cnt", err_cnt, 2);
      send(1'b0, 1'b1);                       // offset 6: clear alone
      check_val("s5_clr_alone_err", err, 0);
      check_val("s5_clr_alone", err_cnt, 0);
      check_val("s5_locked_end", locked, 1);
      $display("scenario 5: saturation and clear complete");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
